mult_sched_8: RTL and testbench

- Round-robin scheduler sharing one pipelined 8x8 unsigned shift-add multiplier (8 cascaded stages, en/rdy valid chain, fixed latency) among NUM_REQ requesters in the FFT datapath.
- Arbitrates operand requests and issues at most one product per cycle into the multiplier.
- Tracks the requester ID of each in-flight product through a tag pipeline aligned to the multiplier latency.
- Returns each 16-bit product to its originating requester, and flags tag/valid misalignment.

---
 rtl/mult_sched_pkg.sv | 39 +++
 rtl/mult_sched_8_if.sv | 27 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/mult_sched_8.sv | 161 ++++++++++++++++
 tb/tb_mult_sched_8.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler and other shared FFT resources.
package mult_sched_pkg;

  // Stage count of the existing 8x8 shift-add multiplier.
  localparam int unsigned MULT8_LATENCY = 8;

  // Widest requester set supported by the shared round-robin helper.
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned TAG_ID_W = 3;

  // In-flight product tag; blocks with fewer requesters use the low id bits.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // One-hot pick of the first asserted request at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [PTR_W-1:0]   idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = PTR_W'((32'(ptr) + k) % n);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mult_sched_8_if.sv
// Requester-side bus of the multiplier scheduler: operand requests, grants and results.
interface mult_sched_8_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   res_valid;
  logic [15:0]          res_data;
  logic [ID_W-1:0]      res_id;

  // Requester side.
  modport master (
    output req, req_a, req_b,
    input  gnt, res_valid, res_data, res_id
  );

  // Scheduler side.
  modport slave (
    input  req, req_a, req_b,
    output gnt, res_valid, res_data, res_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus masked priority pick, combinational grant.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_any_o
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  // Grant search from the pointer; held off entirely while in reset.
  always_comb begin
    pick        = rr_pick(MAX_REQ'(req_i), PTR_W'(ptr_q), NUM_REQ);
    unused_pick = ^(pick >> NUM_REQ);
    gnt_o       = rst_ni ? pick[NUM_REQ-1:0] : '0;
    gnt_any_o   = |gnt_o;
    gnt_idx_o   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) gnt_idx_o = ID_W'(i);
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + ID_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_sched_8.sv
// Shares one pipelined 8x8 multiplier among NUM_REQ requesters; tags each product with its
// requester id and routes the result back, flagging any tag/valid misalignment.
module mult_sched_8
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned MULT_LATENCY = MULT8_LATENCY
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mult_sched_8_if.slave  sched_if,
  output logic           mult_en_o,
  output logic [7:0]     mult_1_o,
  output logic [7:0]     mult_2_o,
  input  logic [15:0]    mult_result_i,
  input  logic           mult_result_rdy_i,
  output logic           busy_o,
  output logic           err_o
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [7:0]         a_sel, b_sel;

  logic               mult_en_q, mult_en_d;
  logic [7:0]         mult_1_q, mult_1_d;
  logic [7:0]         mult_2_q, mult_2_d;
  logic [ID_W-1:0]    issue_id_q, issue_id_d;

  tag_t                     issue_tag;
  tag_t [MULT_LATENCY-1:0]  tag_q;
  tag_t                     tag_out;
  logic [ID_W-1:0]          out_id;
  logic                     tag_any;
  logic                     unused_tag_hi;

  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic               err_q, err_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (sched_if.req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign sched_if.gnt = gnt;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = sched_if.req_a[i*8 +: 8];
        b_sel = sched_if.req_b[i*8 +: 8];
      end
    end
  end

  // Issue stage next-state: operands and id only change on a grant.
  always_comb begin
    mult_en_d  = gnt_any;
    mult_1_d   = mult_1_q;
    mult_2_d   = mult_2_q;
    issue_id_d = issue_id_q;
    if (gnt_any) begin
      mult_1_d   = a_sel;
      mult_2_d   = b_sel;
      issue_id_d = gnt_idx;
    end
  end

  // Issue stage registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mult_en_q  <= 1'b0;
      mult_1_q   <= '0;
      mult_2_q   <= '0;
      issue_id_q <= '0;
    end else begin
      mult_en_q  <= mult_en_d;
      mult_1_q   <= mult_1_d;
      mult_2_q   <= mult_2_d;
      issue_id_q <= issue_id_d;
    end
  end

  assign issue_tag = '{valid: mult_en_q, id: TAG_ID_W'(issue_id_q)};

  // Tag pipe: the tag enters alongside mult_en and leaves when the multiplier raises rdy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= issue_tag;
      for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Tag pipe output and in-flight summary.
  always_comb begin
    tag_out       = tag_q[MULT_LATENCY-1];
    out_id        = tag_out.id[ID_W-1:0];
    unused_tag_hi = ^(tag_out.id >> ID_W);
    tag_any       = 1'b0;
    for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
      tag_any = tag_any | tag_q[i].valid;
    end
  end

  // Return stage next-state: a result is delivered only when tag and rdy agree.
  always_comb begin
    res_valid_d = '0;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    err_d       = err_q | (tag_out.valid ^ mult_result_rdy_i);
    if (tag_out.valid && mult_result_rdy_i) begin
      res_valid_d = NUM_REQ'(1) << out_id;
      res_data_d  = mult_result_i;
      res_id_d    = out_id;
    end
  end

  // Return stage and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      err_q       <= err_d;
    end
  end

  assign sched_if.res_valid = res_valid_q;
  assign sched_if.res_data  = res_data_q;
  assign sched_if.res_id    = res_id_q;

  assign mult_en_o = mult_en_q;
  assign mult_1_o  = mult_1_q;
  assign mult_2_o  = mult_2_q;
  assign busy_o    = mult_en_q | tag_any;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mult_sched_8.sv
// Bench for mult_sched_8: behavioural multiplier, transaction-level scoreboard, scenario tasks.
module tb_mult_sched_8;

  localparam int N   = 4;
  localparam int L   = 8;
  localparam int E2E = L + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_sched_8_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  logic        mult_en;
  logic [7:0]  m1, m2;
  logic [15:0] mres;
  logic        mrdy, busy, err;

  mult_sched_8 #(.NUM_REQ(N), .ID_W(2), .MULT_LATENCY(L)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .sched_if          (bus),
    .mult_en_o         (mult_en),
    .mult_1_o          (m1),
    .mult_2_o          (m2),
    .mult_result_i     (mres),
    .mult_result_rdy_i (mrdy),
    .busy_o            (busy),
    .err_o             (err)
  );

  // Multiplier stand-in: L-stage valid/product pipe; 'early' taps one stage short.
  bit          early = 1'b0;
  logic [15:0] mp_d [L];
  logic        mp_v [L];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        mp_d[i] <= '0;
        mp_v[i] <= 1'b0;
      end
    end else begin
      for (int i = L - 1; i > 0; i--) begin
        mp_d[i] <= mp_d[i-1];
        mp_v[i] <= mp_v[i-1];
      end
      mp_v[0] <= mult_en;
      mp_d[0] <= 16'(m1) * 16'(m2);
    end
  end
  assign mres = early ? mp_d[L-2] : mp_d[L-1];
  assign mrdy = early ? mp_v[L-2] : mp_v[L-1];

  // Reference model state.
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int due; int id; logic [15:0] p;} exp_t;
  exp_t        q[$];
  int          m_ptr = 0;
  logic [3:0]  m_rv = '0;
  logic [15:0] m_data = '0;
  logic [1:0]  m_id = '0;
  logic        m_en = 1'b0;
  logic [7:0]  m_a = '0, m_b = '0;
  int          last_gnt = -100;
  int          err_from = -1;

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    int g;
    if (!rst_n) return 4'b0000;
    g = pick(bus.req, m_ptr);
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  function automatic logic [40:0] obs();
    return {bus.res_valid, bus.res_data, bus.res_id, mult_en, m1, m2, busy, err};
  endfunction

  function automatic logic [40:0] expv();
    logic b, e;
    b = (cyc > last_gnt) && (cyc <= last_gnt + L + 1);
    e = (err_from >= 0) && (cyc >= err_from);
    return {m_rv, m_data, m_id, m_en, m_a, m_b, b, e};
  endfunction

  task automatic drive(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b);
    bus.req   = r;
    bus.req_a = a;
    bus.req_b = b;
    #1;
  endtask

  // Advance one clock, updating the model from the rules for the edge just taken.
  task automatic adv();
    int g;
    bit rs;
    rs = rst_n;
    g  = rs ? pick(bus.req, m_ptr) : -1;
    if (!rs) begin
      m_ptr = 0; q.delete(); m_en = 0; m_a = 0; m_b = 0;
      m_rv = 0; m_data = 0; m_id = 0; last_gnt = -100; err_from = -1;
    end else if (g >= 0) begin
      m_en = 1; m_a = bus.req_a[g*8 +: 8]; m_b = bus.req_b[g*8 +: 8];
      m_ptr = (g + 1) % N; last_gnt = cyc;
      if (early) begin
        if (err_from < 0) err_from = cyc + L + 1;
      end else begin
        q.push_back('{cyc + E2E, g, 16'(m_a) * 16'(m_b)});
      end
    end else begin
      m_en = 0;
    end
    @(posedge clk);
    cyc++;
    if (rs) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        m_rv = 4'b0001 << q[0].id; m_data = q[0].p; m_id = 2'(q[0].id);
        void'(q.pop_front());
      end else begin
        m_rv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(4'hF, $urandom, $urandom);
      checks++;
      if (bus.gnt !== 4'b0000) begin
        failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt);
      end
      adv();
      checks++;
      if (obs() !== 41'd0) begin
        failures++; $display("FAIL reset_outputs got=%h exp=0", obs());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int t0;
    drive(4'b0001, 32'h0000_000C, 32'h0000_000D);
    t0 = cyc;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt);
    end
    adv();
    checks++;
    if ({mult_en, m1, m2} !== {1'b1, 8'h0C, 8'h0D}) begin
      failures++; $display("FAIL single_issue got=%b/%h/%h exp=1/0c/0d", mult_en, m1, m2);
    end
    for (int k = 2; k <= 12; k++) begin
      drive(4'b0000, $urandom, $urandom);
      adv();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL single_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (cyc - t0 == E2E) begin
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_id, err} !== {4'b0001, 16'h009C, 2'd0, 1'b0}) begin
          failures++;
          $display("FAIL single_result got=%b/%h/%0d/%b exp=0001/009c/0/0",
                   bus.res_valid, bus.res_data, bus.res_id, err);
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [15:0] want [4];
    int t0;
    want = '{16'h00FF, 16'h01FE, 16'h02FD, 16'h03FC};
    rst_n = 1'b0; drive(4'h0, 0, 0); adv(); rst_n = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 26; k++) begin
      if (k < 14) drive(4'hF, 32'hFFFF_FFFF, 32'h0403_0201);
      else        drive(4'h0, $urandom, $urandom);
      if (k < 14) begin
        checks++;
        if (bus.gnt !== (4'b0001 << (k % 4))) begin
          failures++; $display("FAIL all4_gnt k=%0d got=%b exp=%b", k, bus.gnt, 4'b0001 << (k % 4));
        end
      end
      adv();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL all4_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (cyc - t0 >= 1 && cyc - t0 <= 13) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++; $display("FAIL all4_busy cyc=%0d got=%b exp=1", cyc, busy);
        end
      end
      if (cyc - t0 >= 10 && cyc - t0 <= 13) begin
        checks++;
        if ({bus.res_data, bus.res_id} !== {want[cyc-t0-10], 2'(cyc - t0 - 10)}) begin
          failures++; $display("FAIL all4_result cyc=%0d got=%h/%0d exp=%h/%0d", cyc,
                               bus.res_data, bus.res_id, want[cyc-t0-10], cyc - t0 - 10);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] rq [4];
    logic [3:0] wg [4];
    rq = '{4'b0100, 4'b1101, 4'b1101, 4'b1101};
    wg = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
    for (int k = 0; k < 16; k++) begin
      drive((k < 4) ? rq[k] : 4'b0000, $urandom, $urandom);
      if (k < 4) begin
        checks++;
        if (bus.gnt !== wg[k]) begin
          failures++; $display("FAIL fair_gnt k=%0d got=%b exp=%b", k, bus.gnt, wg[k]);
        end
      end
      adv();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL fair_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_boundary();
    logic [15:0] seen [$];
    for (int k = 0; k < 18; k++) begin
      if (k == 0)      drive(4'b0001, 32'h0000_0000, 32'h0000_00FF);
      else if (k == 4) drive(4'b1000, 32'hFF00_0000, 32'hFF00_0000);
      else             drive(4'b0000, $urandom, $urandom);
      adv();
      if (bus.res_valid !== 4'b0000) seen.push_back(bus.res_data);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL bound_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 16'h0000 || seen[1] !== 16'hFE01) begin
      failures++; $display("FAIL bound_products got=%0d results exp=2 (0000,fe01)", seen.size());
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int k = 0; k < 92; k++) begin
      r = (k < 80 && $urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      drive(r, $urandom, $urandom);
      checks++;
      if (bus.gnt !== exp_gnt()) begin
        failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt());
      end
      adv();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL rand_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_misalign();
    int nres;
    nres  = 0;
    early = 1'b1;
    for (int k = 0; k < 14; k++) begin
      drive((k == 0) ? 4'b0010 : 4'b0000, $urandom, $urandom);
      adv();
      if (bus.res_valid !== 4'b0000) nres++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL misal_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    early = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, $urandom, $urandom);
      adv();
    end
    checks++;
    if (err !== 1'b1 || nres != 0) begin
      failures++; $display("FAIL misal_sticky got err=%b res=%0d exp err=1 res=0", err, nres);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, $urandom, $urandom);
      adv();
    end
    rst_n = 1'b0;
    drive(4'hF, $urandom, $urandom);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      failures++; $display("FAIL rstmid_gnt got=%b exp=0000", bus.gnt);
    end
    adv();
    rst_n = 1'b1;
    checks++;
    if (obs() !== 41'd0) begin
      failures++; $display("FAIL rstmid_outputs got=%h exp=0", obs());
    end
    for (int k = 0; k < 14; k++) begin
      drive(4'b0000, $urandom, $urandom);
      adv();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL rstmid_stream cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_boundary();
    test_random();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
